// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button conditioner.
// Contents:
//   btn_state_t  - repeat FSM states (IDLE, HOLD, REPEAT)
//   DEB_10MS     - default debounce length in cycles (10 ms at 50 MHz)
//   HOLD_500MS   - default delay from press tick to first repeat (0.5 s)
//   REP_250MS    - default spacing between repeat ticks (0.25 s)
//   CNTW_DEF     - default width of every internal counter
package btn_pkg;

  localparam int DEB_10MS   = 500_000;
  localparam int HOLD_500MS = 25_000_000;
  localparam int REP_250MS  = 12_500_000;
  localparam int CNTW_DEF   = 26;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } btn_state_t;

endpackage

// File: rtl/button_conditioner_if.sv
// Signal bundle between a button conditioner and whatever drives/consumes it.
// Signals:
//   butt_n        raw button, 0 = pressed, asynchronous to the clock
//   en            tick enable; 0 suppresses ticks and parks the FSM
//   pressed       debounced level, 1 = held
//   tick          one-cycle pulse on press and on each auto-repeat
//   release_pulse one-cycle pulse when the debounced level falls
//   repeating     high while auto-repeat is active
// Modports: master drives the button and enable, slave is the conditioner.
interface button_conditioner_if;

  logic butt_n;
  logic en;
  logic pressed;
  logic tick;
  logic release_pulse;
  logic repeating;

  modport master (
    output butt_n,
    output en,
    input  pressed,
    input  tick,
    input  release_pulse,
    input  repeating
  );

  modport slave (
    input  butt_n,
    input  en,
    output pressed,
    output tick,
    output release_pulse,
    output repeating
  );

endinterface

// File: rtl/button_conditioner_debounce.sv
// Two-flop synchroniser plus debounce filter for one active-low button.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   butt_n      raw button input (0 = pressed), asynchronous to clk
//   level       debounced level, 1 = pressed
//   rise        one-cycle strobe, coincident with the first cycle level is 1
//   fall        one-cycle strobe, coincident with the first cycle level is 0
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEB_10MS,
  parameter int CNTW         = CNTW_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic butt_n,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNTW-1:0] DEB_LAST = CNTW'(DEBOUNCE_CYC - 1);

  logic            s1_q, s1_d;
  logic            s2_q, s2_d;
  logic            level_q, level_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            raw_pressed;

  // The counter measures how long the synchronised input has disagreed with
  // the clean level; any agreement restarts it, so only a stable change of
  // DEBOUNCE_CYC cycles flips the level.
  always_comb begin
    s1_d        = butt_n;
    s2_d        = s1_q;
    raw_pressed = ~s2_q;
    level_d     = level_q;
    cnt_d       = '0;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
    if (raw_pressed != level_q) begin
      if (cnt_q == DEB_LAST) begin
        level_d = raw_pressed;
        rise_d  = raw_pressed;
        fall_d  = ~raw_pressed;
      end else begin
        cnt_d = cnt_q + CNTW'(1);
      end
    end
  end

  // Synchroniser flops reset to 1 so a held button after reset is seen as a
  // fresh press once it has been debounced.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: debounces one raw button and produces a tick on
// press followed by auto-repeat ticks while the button stays held.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         button_conditioner_if slave: butt_n/en in;
//               pressed/tick/release_pulse/repeating out
module button_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEB_10MS,
  parameter int HOLD_CYC     = HOLD_500MS,
  parameter int REPEAT_CYC   = REP_250MS,
  parameter int CNTW         = CNTW_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  button_conditioner_if.slave  bus
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_HOLD   = HOLD;
  localparam logic [1:0] ST_REPEAT = REPEAT;

  localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(HOLD_CYC - 1);
  localparam logic [CNTW-1:0] REP_LAST  = CNTW'(REPEAT_CYC - 1);

  logic            level;
  logic            rise;
  logic            fall;
  logic [1:0]      state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            tick_q, tick_d;
  logic            release_q, release_d;

  btn_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .CNTW         (CNTW)
  ) u_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .butt_n (bus.butt_n),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  // Release and disable both take priority over every state, so a repeat
  // tick due in the same cycle as a release is dropped and tick can never
  // coincide with release_pulse. release_pulse follows the fall strobe
  // regardless of en.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tick_d    = 1'b0;
    release_d = fall;
    if (fall || !bus.en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            tick_d  = 1'b1;
            state_d = ST_HOLD;
            cnt_d   = '0;
          end
        end
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            tick_d  = 1'b1;
            cnt_d   = '0;
            state_d = ST_REPEAT;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
        ST_REPEAT: begin
          if (cnt_q == REP_LAST) begin
            tick_d = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + CNTW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      release_q <= release_d;
    end
  end

  assign bus.pressed       = level;
  assign bus.tick          = tick_q;
  assign bus.release_pulse = release_q;
  assign bus.repeating     = (state_q == ST_REPEAT);

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYC=4, HOLD_CYC=10,
// REPEAT_CYC=5. Cycle k is the state after the k-th rising edge following
// the negedge on which butt_n first goes low; butt_n is low for low_cyc edges.
module tb_button_conditioner;

  localparam int DEB  = 4;
  localparam int HLD  = 10;
  localparam int REP  = 5;
  localparam int OBS  = 48;

  typedef struct {
    string       name;
    int          low_cyc;
    int          rise_k;
    int          fall_k;
    logic [63:0] tick_mask;
    int          rep_k;
    int          rel_k;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  vec_t vecs[5];

  always #5 clk = ~clk;

  button_conditioner_if bus ();

  button_conditioner #(
    .DEBOUNCE_CYC (DEB),
    .HOLD_CYC     (HLD),
    .REPEAT_CYC   (REP),
    .CNTW         (26)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // One comparison: counts it and reports a mismatch.
  task automatic check_output(input string name, input int k,
                              input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s cycle %0d: got %b, want %b", name, k, act, exp);
    end
  endtask

  // Plays one table record from an idle start and checks every cycle.
  task automatic apply_stimulus(input vec_t v);
    logic exp_p;
    logic exp_r;
    @(negedge clk);
    bus.butt_n = 1'b0;
    for (int k = 1; k <= OBS; k++) begin
      @(negedge clk);
      exp_p = (v.rise_k != 0) && (k >= v.rise_k) && (k < v.fall_k);
      exp_r = (v.rep_k != 0) && (k >= v.rep_k) && (k < v.rel_k);
      check_output({v.name, ".pressed"}, k, bus.pressed, exp_p);
      check_output({v.name, ".tick"}, k, bus.tick, v.tick_mask[k]);
      check_output({v.name, ".release"}, k, bus.release_pulse, k == v.rel_k);
      check_output({v.name, ".repeating"}, k, bus.repeating, exp_r);
      bus.butt_n = (k < v.low_cyc) ? 1'b0 : 1'b1;
    end
  endtask

  // Reset asserted during auto-repeat with the button held, then released
  // while the button is still held.
  task automatic reset_sequence();
    @(negedge clk);
    bus.butt_n = 1'b0;
    for (int k = 1; k <= 20; k++) @(negedge clk);
    check_output("rst.pre_repeating", 20, bus.repeating, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_output("rst.pressed", 0, bus.pressed, 1'b0);
    check_output("rst.tick", 0, bus.tick, 1'b0);
    check_output("rst.release", 0, bus.release_pulse, 1'b0);
    check_output("rst.repeating", 0, bus.repeating, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check_output("rst.held_pressed", k, bus.pressed, k >= 6);
      check_output("rst.held_tick", k, bus.tick, k == 7);
      check_output("rst.held_release", k, bus.release_pulse, 1'b0);
    end
    bus.butt_n = 1'b1;
    for (int k = 10; k <= 22; k++) @(negedge clk);
    check_output("rst.idle_pressed", 22, bus.pressed, 1'b0);
  endtask

  // en dropped during a held press, raised again while still held, then the
  // button is released and pressed afresh.
  task automatic enable_sequence();
    @(negedge clk);
    bus.butt_n = 1'b0;
    for (int k = 1; k <= 56; k++) begin
      @(negedge clk);
      if (k <= 12) begin
        check_output("en.tick_before", k, bus.tick, k == 7);
      end else begin
        check_output("en.tick_gated", k, bus.tick, 1'b0);
        check_output("en.repeating", k, bus.repeating, 1'b0);
        check_output("en.pressed", k, bus.pressed, k < 50);
        check_output("en.release", k, bus.release_pulse, k == 51);
      end
      if (k == 12) bus.en = 1'b0;
      if (k == 30) bus.en = 1'b1;
      if (k == 44) bus.butt_n = 1'b1;
    end
    apply_stimulus(vecs[1]);
  endtask

  initial begin
    vecs[0] = '{"glitch3", 3, 0, 0, 64'd0, 0, 0};
    vecs[1] = '{"single8", 8, 6, 14, (64'd1 << 7), 0, 15};
    vecs[2] = '{"min4", 4, 6, 10, (64'd1 << 7), 0, 11};
    vecs[3] = '{"hold34", 34, 6, 40,
                (64'd1 << 7) | (64'd1 << 17) | (64'd1 << 22) |
                (64'd1 << 27) | (64'd1 << 32) | (64'd1 << 37), 17, 41};
    vecs[4] = '{"collide25", 25, 6, 31,
                (64'd1 << 7) | (64'd1 << 17) | (64'd1 << 22) |
                (64'd1 << 27), 17, 32};

    rst_n      = 1'b0;
    bus.butt_n = 1'b1;
    bus.en     = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_output("init.pressed", 0, bus.pressed, 1'b0);
    check_output("init.tick", 0, bus.tick, 1'b0);
    check_output("init.release", 0, bus.release_pulse, 1'b0);
    check_output("init.repeating", 0, bus.repeating, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      $display("[TB] vector %s", vecs[i].name);
      apply_stimulus(vecs[i]);
    end

    $display("[TB] reset during repeat");
    reset_sequence();

    $display("[TB] enable gating");
    enable_sequence();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
